// File: rtl/execute_stage_fwd_if.sv
// ---------------------------------------------------------------------------
// execute_stage_fwd_if
//   Bundles every non-clock/reset signal of the execute stage: the ID/EX
//   instruction fields, the EX/MEM and MEM/WB forwarding buses, and the
//   registered EX/MEM outputs plus the busy stall.
//
//   Modports
//     master : the surrounding pipeline (drives instruction and forwarding
//              buses, receives results and busy)
//     slave  : the execute stage itself
//
//   Parameters must match those of the execute_stage_fwd instance it binds.
// ---------------------------------------------------------------------------
interface execute_stage_fwd_if #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int OP_W       = 4
);
  // ID/EX instruction fields
  logic                  inValid;
  logic [1:0]            writeBackControlIn;
  logic [1:0]            memAccessControlIn;
  logic [OP_W-1:0]       aluOp;
  logic                  useImmediate;
  logic [WIDTH-1:0]      readData1;
  logic [WIDTH-1:0]      readData2;
  logic [WIDTH-1:0]      immediateOperand;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [REG_ADDR_W-1:0] rdIn;

  // Forwarding sources
  logic                  exMemRegWrite;
  logic [REG_ADDR_W-1:0] exMemRd;
  logic [WIDTH-1:0]      exMemData;
  logic                  memWbRegWrite;
  logic [REG_ADDR_W-1:0] memWbRd;
  logic [WIDTH-1:0]      memWbData;

  // EX/MEM register outputs and stall
  logic [1:0]            writeBackControlOut;
  logic [1:0]            memAccessControlOut;
  logic [WIDTH-1:0]      result;
  logic [WIDTH-1:0]      writeData;
  logic [REG_ADDR_W-1:0] rdOut;
  logic                  outValid;
  logic                  busy;

  modport master (
    output inValid, writeBackControlIn, memAccessControlIn, aluOp, useImmediate,
           readData1, readData2, immediateOperand, rs, rt, rdIn,
           exMemRegWrite, exMemRd, exMemData, memWbRegWrite, memWbRd, memWbData,
    input  writeBackControlOut, memAccessControlOut, result, writeData, rdOut,
           outValid, busy
  );

  modport slave (
    input  inValid, writeBackControlIn, memAccessControlIn, aluOp, useImmediate,
           readData1, readData2, immediateOperand, rs, rt, rdIn,
           exMemRegWrite, exMemRd, exMemData, memWbRegWrite, memWbRd, memWbData,
    output writeBackControlOut, memAccessControlOut, result, writeData, rdOut,
           outValid, busy
  );
endinterface

// File: rtl/execute_stage_fwd.sv
// ---------------------------------------------------------------------------
// execute_stage_fwd
//   Pipeline EX stage. Picks each source operand with two-level forwarding
//   (EX/MEM beats MEM/WB beats the register file), runs the ALU and registers
//   the result, store data, destination and pass-through controls into the
//   EX/MEM pipeline register.
//
//   Ports
//     clk    : pipeline clock, rising edge
//     reset  : asynchronous, active-high; clears every output and the FSM
//     bus    : execute_stage_fwd_if.slave (instruction, forwarding buses,
//              registered results, busy stall)
//
//   Configuration
//     MULDIV_EN : when defined, aluOp 8 runs a shift-add multiplier that
//                 takes one bit per cycle (IDLE/MUL/DONE FSM) and stalls the
//                 front end through busy. When undefined, busy is tied low and
//                 aluOp 8 behaves as an unknown op.
//
//   Unknown ops produce result 0 and suppress both control fields so the
//   instruction cannot write a register or touch memory.
// ---------------------------------------------------------------------------
module execute_stage_fwd #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int OP_W       = 4
) (
  input logic              clk,
  input logic              reset,
  execute_stage_fwd_if.slave bus
);

  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLT = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SLL = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRL = OP_W'(7);

  // -------------------------------------------------------------------------
  // Operand selection. Register 0 is not special: it forwards like any other.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] fwdA;
  logic [WIDTH-1:0] fwdRt;
  logic [WIDTH-1:0] opB;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    fwdA  = bus.readData1;
    fwdRt = bus.readData2;

    if (bus.exMemRegWrite && (bus.exMemRd == bus.rs))
      fwdA = bus.exMemData;
    else if (bus.memWbRegWrite && (bus.memWbRd == bus.rs))
      fwdA = bus.memWbData;

    if (bus.exMemRegWrite && (bus.exMemRd == bus.rt))
      fwdRt = bus.exMemData;
    else if (bus.memWbRegWrite && (bus.memWbRd == bus.rt))
      fwdRt = bus.memWbData;

    opB = bus.useImmediate ? bus.immediateOperand : fwdRt;
  end

  // -------------------------------------------------------------------------
  // Single-cycle ALU
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] aluRes;
  logic             aluKnown;

  always_comb begin
    aluRes   = '0;
    aluKnown = 1'b1;
    case (bus.aluOp)
      OP_ADD:  aluRes = fwdA + opB;
      OP_SUB:  aluRes = fwdA - opB;
      OP_AND:  aluRes = fwdA & opB;
      OP_OR:   aluRes = fwdA | opB;
      OP_XOR:  aluRes = fwdA ^ opB;
      OP_SLT:  aluRes = {{(WIDTH-1){1'b0}}, ($signed(fwdA) < $signed(opB))};
      OP_SLL:  aluRes = fwdA << opB[SHAMT_W-1:0];
      OP_SRL:  aluRes = fwdA >> opB[SHAMT_W-1:0];
      default: aluKnown = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Iterative multiplier control
  // -------------------------------------------------------------------------
  logic acceptAlu;  // this cycle's inputs go through the single-cycle path
  logic busyInt;

`ifdef MULDIV_EN
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(8);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t               state;
  state_t               stateNext;
  logic                 startMul;
  logic                 finishMul;
  logic                 isMul;

  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic [SHAMT_W-1:0]   cnt;
  logic [WIDTH-1:0]     mulWriteData;
  logic [REG_ADDR_W-1:0] mulRd;
  logic [1:0]           mulWb;
  logic [1:0]           mulMem;

  assign isMul = bus.inValid && (bus.aluOp == OP_MUL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // busy is raised in the accepting IDLE cycle and through every MUL cycle.
  // DONE never stalls: it presents the product and samples the next
  // instruction in the same cycle; a MUL arriving in DONE restarts directly.
  always_comb begin
    stateNext = state;
    startMul  = 1'b0;
    finishMul = 1'b0;
    acceptAlu = 1'b0;
    busyInt   = 1'b0;
    case (state)
      IDLE: begin
        if (isMul) begin
          startMul  = 1'b1;
          busyInt   = 1'b1;
          stateNext = MUL;
        end else begin
          acceptAlu = 1'b1;
        end
      end
      MUL: begin
        busyInt = 1'b1;
        if (cnt == SHAMT_W'(WIDTH - 1)) begin
          finishMul = 1'b1;
          stateNext = DONE;
        end
      end
      DONE: begin
        if (isMul) begin
          startMul  = 1'b1;
          stateNext = MUL;
        end else begin
          acceptAlu = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Shift-add datapath: one multiplier bit consumed per MUL cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      cnt          <= '0;
      mulWriteData <= '0;
      mulRd        <= '0;
      mulWb        <= '0;
      mulMem       <= '0;
    end else if (startMul) begin
      acc          <= '0;
      mcand        <= fwdA;
      mplier       <= opB;
      cnt          <= '0;
      mulWriteData <= fwdRt;
      mulRd        <= bus.rdIn;
      mulWb        <= bus.writeBackControlIn;
      mulMem       <= bus.memAccessControlIn;
    end else if (state == MUL) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + SHAMT_W'(1);
    end
  end
`else
  assign acceptAlu = 1'b1;
  assign busyInt   = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // EX/MEM pipeline register
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0]      resultQ;
  logic [WIDTH-1:0]      writeDataQ;
  logic [REG_ADDR_W-1:0] rdQ;
  logic [1:0]            wbQ;
  logic [1:0]            memQ;
  logic                  outValidQ;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      resultQ    <= '0;
      writeDataQ <= '0;
      rdQ        <= '0;
      wbQ        <= '0;
      memQ       <= '0;
      outValidQ  <= 1'b0;
    end
`ifdef MULDIV_EN
    else if (finishMul) begin
      // Last partial product folded in on the way out.
      resultQ    <= acc + (mplier[0] ? mcand : '0);
      writeDataQ <= mulWriteData;
      rdQ        <= mulRd;
      wbQ        <= mulWb;
      memQ       <= mulMem;
      outValidQ  <= 1'b1;
    end else if (startMul) begin
      resultQ    <= '0;
      writeDataQ <= '0;
      rdQ        <= '0;
      wbQ        <= '0;
      memQ       <= '0;
      outValidQ  <= 1'b0;
    end
`endif
    else if (acceptAlu) begin
      resultQ    <= aluRes;
      writeDataQ <= fwdRt;
      rdQ        <= bus.rdIn;
      wbQ        <= (bus.inValid && aluKnown) ? bus.writeBackControlIn : 2'b00;
      memQ       <= (bus.inValid && aluKnown) ? bus.memAccessControlIn : 2'b00;
      outValidQ  <= bus.inValid;
    end
  end

  assign bus.result              = resultQ;
  assign bus.writeData           = writeDataQ;
  assign bus.rdOut               = rdQ;
  assign bus.writeBackControlOut = wbQ;
  assign bus.memAccessControlOut = memQ;
  assign bus.outValid            = outValidQ;
  assign bus.busy                = busyInt;

endmodule

// File: tb/tb_execute_stage_fwd.sv
// ---------------------------------------------------------------------------
// tb_execute_stage_fwd
//   Random and directed instructions are driven at the falling edge; each
//   issued instruction's expected EX/MEM contents are queued. A monitor
//   samples 1 ns after every rising edge and pops one entry per outValid.
//   Build with +define+MULDIV_EN to exercise the multiplier.
// ---------------------------------------------------------------------------
module tb_execute_stage_fwd;
  localparam int WIDTH = 32;
  localparam int RA    = 5;
  localparam int OPW   = 4;
`ifdef MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  execute_stage_fwd_if #(.WIDTH(WIDTH), .REG_ADDR_W(RA), .OP_W(OPW)) bus ();

  execute_stage_fwd #(.WIDTH(WIDTH), .REG_ADDR_W(RA), .OP_W(OPW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic        inValid;
    logic [1:0]  wb;
    logic [1:0]  mem;
    logic [3:0]  op;
    logic        useImm;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        exW;
    logic [4:0]  exRd;
    logic [31:0] exD;
    logic        wbW;
    logic [4:0]  wbRd;
    logic [31:0] wbD;
  } instr_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] writeData;
    logic [4:0]  rd;
    logic [1:0]  wb;
    logic [1:0]  mem;
  } exp_t;

  exp_t sb[$];
  exp_t monExp;
  int   checks = 0;
  int   errors = 0;
  bit   prevMulDone = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] pick(input logic [4:0] r, input logic [31:0] rf, input instr_t t);
    if (t.exW && t.exRd == r) return t.exD;
    if (t.wbW && t.wbRd == r) return t.wbD;
    return rf;
  endfunction

  function automatic exp_t model(input instr_t t);
    exp_t        m;
    logic [31:0] a, rv, b, r;
    bit          known;
    a     = pick(t.rs, t.rd1, t);
    rv    = pick(t.rt, t.rd2, t);
    b     = t.useImm ? t.imm : rv;
    known = 1'b1;
    case (t.op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: r = a << b[4:0];
      4'd7: r = a >> b[4:0];
      4'd8: begin
        if (MULDIV) r = a * b;
        else begin r = 32'd0; known = 1'b0; end
      end
      default: begin r = 32'd0; known = 1'b0; end
    endcase
    m.result    = r;
    m.writeData = rv;
    m.rd        = t.rd;
    m.wb        = known ? t.wb : 2'b00;
    m.mem       = known ? t.mem : 2'b00;
    return m;
  endfunction

  function automatic instr_t randInstr();
    instr_t t;
    t.inValid = ($urandom_range(0, 9) != 0);
    t.wb      = 2'($urandom_range(0, 3));
    t.mem     = 2'($urandom_range(0, 3));
    t.op      = 4'($urandom_range(0, 8));
    t.useImm  = $urandom_range(0, 1) == 1;
    t.rd1     = $urandom;
    t.rd2     = $urandom;
    t.imm     = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
    t.rs      = 5'($urandom_range(0, 3));
    t.rt      = 5'($urandom_range(0, 3));
    t.rd      = 5'($urandom_range(0, 31));
    t.exW     = $urandom_range(0, 1) == 1;
    t.exRd    = 5'($urandom_range(0, 3));
    t.exD     = $urandom;
    t.wbW     = $urandom_range(0, 1) == 1;
    t.wbRd    = 5'($urandom_range(0, 3));
    t.wbD     = $urandom;
    return t;
  endfunction

  task automatic drive(input instr_t t);
    bus.inValid            = t.inValid;
    bus.writeBackControlIn = t.wb;
    bus.memAccessControlIn = t.mem;
    bus.aluOp              = t.op;
    bus.useImmediate       = t.useImm;
    bus.readData1          = t.rd1;
    bus.readData2          = t.rd2;
    bus.immediateOperand   = t.imm;
    bus.rs                 = t.rs;
    bus.rt                 = t.rt;
    bus.rdIn               = t.rd;
    bus.exMemRegWrite      = t.exW;
    bus.exMemRd            = t.exRd;
    bus.exMemData          = t.exD;
    bus.memWbRegWrite      = t.wbW;
    bus.memWbRd            = t.wbRd;
    bus.memWbData          = t.wbD;
  endtask

  // Called at a falling edge; returns at the falling edge where the stage
  // samples the next instruction. While busy, garbage is driven to prove it
  // is ignored.
  task automatic issue(input instr_t t, input bit ovr, input exp_t e);
    int nBusy;
    bit isMul;
    drive(t);
    isMul = MULDIV && t.inValid && (t.op == 4'd8);
    if (t.inValid) sb.push_back(ovr ? e : model(t));
    #1;
    nBusy = bus.busy ? 1 : 0;
    forever begin
      @(negedge clk);
      if (!bus.busy || nBusy > 200) break;
      nBusy++;
      drive(randInstr());
    end
    if (isMul) check("mul_busy_cycles", 64'(nBusy), prevMulDone ? 64'(WIDTH) : 64'(WIDTH + 1));
    else       check("busy_low", 64'(nBusy), 64'd0);
    prevMulDone = isMul;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (!reset && bus.outValid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_outValid", 64'd1, 64'd0);
      end else begin
        monExp = sb.pop_front();
        check("result",    64'(bus.result),              64'(monExp.result));
        check("writeData", 64'(bus.writeData),           64'(monExp.writeData));
        check("rdOut",     64'(bus.rdOut),               64'(monExp.rd));
        check("wbCtl",     64'(bus.writeBackControlOut), 64'(monExp.wb));
        check("memCtl",    64'(bus.memAccessControlOut), 64'(monExp.mem));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    instr_t t;
    exp_t   e;
    reset = 1'b1;
    t = '0;
    drive(t);
    repeat (2) @(posedge clk);
    #1;
    check("rst_outValid", 64'(bus.outValid), 64'd0);
    check("rst_result",   64'(bus.result), 64'd0);
    check("rst_writeData",64'(bus.writeData), 64'd0);
    check("rst_rdOut",    64'(bus.rdOut), 64'd0);
    check("rst_wbCtl",    64'(bus.writeBackControlOut), 64'd0);
    check("rst_memCtl",   64'(bus.memAccessControlOut), 64'd0);
    check("rst_busy",     64'(bus.busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // ADD with MEM/WB forwarding of rs
    t = '0; t.inValid = 1; t.op = 4'd0; t.rs = 1; t.rt = 2; t.rd = 0;
    t.rd1 = 15; t.rd2 = 1; t.wbW = 1; t.wbRd = 1; t.wbD = 255; t.wb = 2'b01; t.mem = 2'b10;
    e = '{result: 32'd256, writeData: 32'd1, rd: 5'd0, wb: 2'b01, mem: 2'b10};
    issue(t, 1'b1, e);

    // EX/MEM has priority over MEM/WB for the same register
    t = '0; t.inValid = 1; t.op = 4'd3; t.rs = 3; t.rt = 5; t.rd = 4; t.useImm = 1;
    t.imm = 0; t.rd1 = 0; t.rd2 = 32'h55; t.exW = 1; t.exRd = 3; t.exD = 7;
    t.wbW = 1; t.wbRd = 3; t.wbD = 9; t.wb = 2'b11; t.mem = 2'b00;
    e = '{result: 32'd7, writeData: 32'h55, rd: 5'd4, wb: 2'b11, mem: 2'b00};
    issue(t, 1'b1, e);

    // Register 0 forwards like any other
    t = '0; t.inValid = 1; t.op = 4'd0; t.rs = 0; t.rt = 7; t.rd = 1; t.useImm = 1;
    t.rd1 = 32'hdead; t.rd2 = 3; t.exW = 1; t.exRd = 0; t.exD = 32'h1234; t.wb = 2'b01;
    e = '{result: 32'h1234, writeData: 32'd3, rd: 5'd1, wb: 2'b01, mem: 2'b00};
    issue(t, 1'b1, e);

    // SUB with immediate
    t = '0; t.inValid = 1; t.op = 4'd1; t.useImm = 1; t.rs = 1; t.rt = 2; t.rd = 2;
    t.rd1 = 3; t.rd2 = 9; t.imm = 1; t.wb = 2'b10;
    e = '{result: 32'd2, writeData: 32'd9, rd: 5'd2, wb: 2'b10, mem: 2'b00};
    issue(t, 1'b1, e);

    // SLT signed: -1 < 1
    t = '0; t.inValid = 1; t.op = 4'd5; t.rs = 1; t.rt = 2; t.rd = 3;
    t.rd1 = 32'hffff_ffff; t.rd2 = 1; t.wb = 2'b01;
    e = '{result: 32'd1, writeData: 32'd1, rd: 5'd3, wb: 2'b01, mem: 2'b00};
    issue(t, 1'b1, e);

    // SRL by the maximum shift amount
    t = '0; t.inValid = 1; t.op = 4'd7; t.useImm = 1; t.rs = 1; t.rt = 2; t.rd = 5;
    t.rd1 = 32'h8000_0000; t.rd2 = 6; t.imm = 31; t.wb = 2'b01;
    e = '{result: 32'd1, writeData: 32'd6, rd: 5'd5, wb: 2'b01, mem: 2'b00};
    issue(t, 1'b1, e);

    // aluOp 8: product with the multiplier, unknown op without it
    t = '0; t.inValid = 1; t.op = 4'd8; t.rs = 1; t.rt = 2; t.rd = 9;
    t.rd1 = 6; t.rd2 = 7; t.wb = 2'b11; t.mem = 2'b01;
    if (MULDIV) e = '{result: 32'd42, writeData: 32'd7, rd: 5'd9, wb: 2'b11, mem: 2'b01};
    else        e = '{result: 32'd0,  writeData: 32'd7, rd: 5'd9, wb: 2'b00, mem: 2'b00};
    issue(t, 1'b1, e);

    // Bubble then random traffic
    t = '0;
    issue(t, 1'b0, e);
    for (int i = 0; i < 300; i++) issue(randInstr(), 1'b0, e);

    // Reset in the middle of a multiply: nothing may come out afterwards
    if (MULDIV) begin
      t = '0; t.inValid = 1; t.op = 4'd8; t.rd1 = 5; t.rd2 = 9; t.wb = 2'b11; t.rd = 7;
      drive(t);
      repeat (10) begin
        @(negedge clk);
        drive(randInstr());
      end
      bus.inValid = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("mulrst_busy",     64'(bus.busy), 64'd0);
      check("mulrst_outValid", 64'(bus.outValid), 64'd0);
      check("mulrst_result",   64'(bus.result), 64'd0);
      check("mulrst_wbCtl",    64'(bus.writeBackControlOut), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      prevMulDone = 1'b0;
      t = '0;
      drive(t);
      repeat (45) @(negedge clk);
      check("mulrst_busy_after", 64'(bus.busy), 64'd0);
    end

    t = '0;
    drive(t);
    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
